// File: rtl/slcorem0_rstreq_defs.sv
// Shared definitions for the SLCore-M0 system reset request controller:
// FSM state encodings, SYS_RSTINFO cause bit positions and small helpers.
package slcorem0_rstreq_defs;

  // Width of every cycle counter in the block (hold, ack wait, lockup).
  localparam int CNT_W = 8;

  // Width of the sticky cause record and the position of each source in it.
  localparam int INFO_W      = 4;
  localparam int INFO_CORE   = 0;
  localparam int INFO_WDOG   = 1;
  localparam int INFO_LOCKUP = 2;
  localparam int INFO_SW     = 3;

  // Request sequencer states; the encodings are fixed so that debug tools
  // reading the state register see stable values.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_WAITACK = 2'd2,
    ST_WAITREL = 2'd3
  } rst_state_e;

  // Place each active request source at its cause bit position.
  function automatic logic [INFO_W-1:0] pack_cause(input logic core,
                                                   input logic wdog,
                                                   input logic lockup,
                                                   input logic sw);
    logic [INFO_W-1:0] cause;
    cause              = '0;
    cause[INFO_CORE]   = core;
    cause[INFO_WDOG]   = wdog;
    cause[INFO_LOCKUP] = lockup;
    cause[INFO_SW]     = sw;
    return cause;
  endfunction

  // Down-counters run from N-1 to 0, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/slcorem0_lockup_timer.sv
// Qualified core lockup timer. Counts consecutive cycles in which the core
// reports lockup, lockup resets are enabled and the request sequencer is
// idle; fires once the lockup has persisted for LOCKUP_DELAY cycles.
module slcorem0_lockup_timer
  import slcorem0_rstreq_defs::*;
#(
  parameter int LOCKUP_DELAY = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic core_lockup,
  input  logic lockup_en,
  input  logic fsm_idle,
  output logic lockup_fire
);

  logic             qual_lockup;
  logic [CNT_W-1:0] count_q;

  // A lockup only counts while it is enabled and no request is in flight;
  // any break in the qualification restarts the delay from zero.
  assign qual_lockup = core_lockup & lockup_en & fsm_idle;

  // Consecutive-cycle counter; saturates so it can never wrap back into range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (!qual_lockup) begin
      count_q <= '0;
    end else if (count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Fire on the LOCKUP_DELAY-th consecutive qualified cycle, so a lockup
  // starting in cycle 0 raises the request in cycle LOCKUP_DELAY.
  assign lockup_fire = qual_lockup && (count_q == cnt_load(LOCKUP_DELAY));

endmodule

// File: rtl/slcorem0_rstreq.sv
// System reset request controller for SLCore-M0. Merges the core, watchdog,
// software and lockup reset requests into one stretched request towards the
// PRMU, waits for the PRMU to acknowledge by pulling SYS_HRESETn low, and
// keeps a sticky record of what caused it. Runs only on the free-running
// clock and power-on reset so the cause record survives the system reset.
module slcorem0_rstreq
  import slcorem0_rstreq_defs::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int LOCKUP_DELAY = 16
) (
  input  logic              SYS_FCLK,
  input  logic              SYS_PORESET,
  input  logic              CORE_SYSRESETREQ,
  input  logic              CORE_LOCKUP,
  input  logic              SYS_LOCKUPRESETEN,
  input  logic              SYS_WDOGRESETREQ,
  input  logic              SYS_SWRESETREQ,
  input  logic              SYS_HRESETn,
  input  logic              SYS_RSTINFOCLR,
  output logic              SYS_SYSRESETREQ,
  output logic [INFO_W-1:0] SYS_RSTINFO,
  output logic              SYS_RSTTIMEOUT
);

  // Parameters outside the 8-bit counter range are rejected at elaboration.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_range
    $error("slcorem0_rstreq: HOLD_CYCLES must be in 1..255");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_ack_range
    $error("slcorem0_rstreq: ACK_TIMEOUT must be in 1..255");
  end
  if (LOCKUP_DELAY < 1 || LOCKUP_DELAY > 255) begin : g_lockup_range
    $error("slcorem0_rstreq: LOCKUP_DELAY must be in 1..255");
  end

  rst_state_e        state_q;
  rst_state_e        state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              req_q;
  logic              req_d;
  logic [INFO_W-1:0] info_q;
  logic [INFO_W-1:0] info_d;
  logic              timeout_q;
  logic              timeout_d;
  logic [INFO_W-1:0] cause_set;
  logic              timeout_set;
  logic              lockup_fire;
  logic              trigger;

  slcorem0_lockup_timer #(
    .LOCKUP_DELAY (LOCKUP_DELAY)
  ) u_lockup_timer (
    .clk         (SYS_FCLK),
    .rst         (SYS_PORESET),
    .core_lockup (CORE_LOCKUP),
    .lockup_en   (SYS_LOCKUPRESETEN),
    .fsm_idle    (state_q == ST_IDLE),
    .lockup_fire (lockup_fire)
  );

  // Any source can start a sequence; only IDLE acts on it.
  assign trigger = CORE_SYSRESETREQ | SYS_WDOGRESETREQ | SYS_SWRESETREQ | lockup_fire;

  // Sequencer next state: hold the request for HOLD_CYCLES, then wait up to
  // ACK_TIMEOUT cycles for the PRMU, then wait for everything to settle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cause_set   = '0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d   = ST_ASSERT;
          count_d   = cnt_load(HOLD_CYCLES);
          cause_set = pack_cause(CORE_SYSRESETREQ, SYS_WDOGRESETREQ,
                                 lockup_fire, SYS_SWRESETREQ);
        end
      end
      ST_ASSERT: begin
        if (count_q == '0) begin
          state_d = ST_WAITACK;
          count_d = cnt_load(ACK_TIMEOUT);
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_WAITACK: begin
        if (!SYS_HRESETn) begin
          state_d = ST_WAITREL;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d     = ST_WAITREL;
          timeout_set = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_WAITREL: begin
        if (SYS_HRESETn && !CORE_SYSRESETREQ && !SYS_WDOGRESETREQ) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Request and sticky flag updates; a new cause in the same cycle as the
  // clear survives the clear for its own bit.
  always_comb begin
    req_d     = (state_d == ST_ASSERT) || (state_d == ST_WAITACK);
    info_d    = (info_q & ~{INFO_W{SYS_RSTINFOCLR}}) | cause_set;
    timeout_d = (timeout_q & ~SYS_RSTINFOCLR) | timeout_set;
  end

  // State, counter, registered request and sticky record; power-on reset
  // wipes all of it, including the cause bits.
  always_ff @(posedge SYS_FCLK or posedge SYS_PORESET) begin
    if (SYS_PORESET) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      req_q     <= 1'b0;
      info_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      req_q     <= req_d;
      info_q    <= info_d;
      timeout_q <= timeout_d;
    end
  end

  assign SYS_SYSRESETREQ = req_q;
  assign SYS_RSTINFO     = info_q;
  assign SYS_RSTTIMEOUT  = timeout_q;

endmodule

// File: tb/tb_slcorem0_rstreq.sv
// Self-checking bench for slcorem0_rstreq: directed scenarios followed by
// randomized request sequences checked against a cycle-count reference model.
module tb_slcorem0_rstreq;

  localparam int HOLD = 4;
  localparam int ACK  = 64;
  localparam int LDLY = 16;

  logic       SYS_FCLK = 1'b0;
  logic       SYS_PORESET = 1'b0;
  logic       CORE_SYSRESETREQ = 1'b0;
  logic       CORE_LOCKUP = 1'b0;
  logic       SYS_LOCKUPRESETEN = 1'b0;
  logic       SYS_WDOGRESETREQ = 1'b0;
  logic       SYS_SWRESETREQ = 1'b0;
  logic       SYS_HRESETn = 1'b1;
  logic       SYS_RSTINFOCLR = 1'b0;
  logic       SYS_SYSRESETREQ;
  logic [3:0] SYS_RSTINFO;
  logic       SYS_RSTTIMEOUT;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: the sticky record as the rules say it should read.
  logic [3:0] exp_info = 4'b0000;
  logic       exp_to   = 1'b0;

  slcorem0_rstreq #(
    .HOLD_CYCLES  (HOLD),
    .ACK_TIMEOUT  (ACK),
    .LOCKUP_DELAY (LDLY)
  ) dut (
    .SYS_FCLK          (SYS_FCLK),
    .SYS_PORESET       (SYS_PORESET),
    .CORE_SYSRESETREQ  (CORE_SYSRESETREQ),
    .CORE_LOCKUP       (CORE_LOCKUP),
    .SYS_LOCKUPRESETEN (SYS_LOCKUPRESETEN),
    .SYS_WDOGRESETREQ  (SYS_WDOGRESETREQ),
    .SYS_SWRESETREQ    (SYS_SWRESETREQ),
    .SYS_HRESETn       (SYS_HRESETn),
    .SYS_RSTINFOCLR    (SYS_RSTINFOCLR),
    .SYS_SYSRESETREQ   (SYS_SYSRESETREQ),
    .SYS_RSTINFO       (SYS_RSTINFO),
    .SYS_RSTTIMEOUT    (SYS_RSTTIMEOUT)
  );

  always #5 SYS_FCLK = ~SYS_FCLK;

  task automatic tick();
    @(posedge SYS_FCLK);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Request length model: the request rises after the trigger edge, the
  // acknowledge is only honoured once the hold phase is over, and the wait
  // gives up after HOLD+ACK cycles in total.
  function automatic int model_len(input int ack_at);
    int len;
    len = ack_at;
    if (len < HOLD + 1) len = HOLD + 1;
    if (len > HOLD + ACK) len = HOLD + ACK;
    return len;
  endfunction

  // Count request-high cycles starting right after the trigger edge; the
  // acknowledge goes low from edge ack_at (relative to the trigger) onward.
  task automatic measure(input int ack_at, output int len);
    int j;
    len = 0;
    j   = 0;
    while (SYS_SYSRESETREQ === 1'b1 && j < 400) begin
      len++;
      j++;
      SYS_HRESETn = (j >= ack_at) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  // Fire one request from the given sources (optionally with a clear in the
  // same cycle) and check its length and the resulting sticky record.
  task automatic apply_stimulus(input logic core, input logic wdog, input logic sw,
                                input logic clr, input int ack_at, input string tag);
    int len;
    CORE_SYSRESETREQ = core;
    SYS_WDOGRESETREQ = wdog;
    SYS_SWRESETREQ   = sw;
    SYS_RSTINFOCLR   = clr;
    SYS_HRESETn      = 1'b1;
    tick();
    CORE_SYSRESETREQ = 1'b0;
    SYS_WDOGRESETREQ = 1'b0;
    SYS_SWRESETREQ   = 1'b0;
    SYS_RSTINFOCLR   = 1'b0;
    if (clr) begin
      exp_info = 4'b0000;
      exp_to   = 1'b0;
    end
    exp_info = exp_info | {sw, 1'b0, wdog, core};
    check_output({tag, "_req_rise"}, int'(SYS_SYSRESETREQ), 1);
    measure(ack_at, len);
    if (ack_at > HOLD + ACK) exp_to = 1'b1;
    check_output({tag, "_req_len"}, len, model_len(ack_at));
    check_output({tag, "_info"}, int'(SYS_RSTINFO), int'(exp_info));
    check_output({tag, "_timeout"}, int'(SYS_RSTTIMEOUT), int'(exp_to));
  endtask

  // Release the acknowledge and confirm nothing starts again on its own.
  task automatic release_idle(input string tag);
    SYS_HRESETn = 1'b1;
    repeat (3) tick();
    check_output({tag, "_quiet"}, int'(SYS_SYSRESETREQ), 0);
  endtask

  initial begin
    int         len;
    logic       seen;
    logic       rc;
    logic       rw;
    logic       rs;
    logic       rclr;
    int         ra;

    // Power-on reset
    #2 SYS_PORESET = 1'b1;
    #1;
    check_output("por_req", int'(SYS_SYSRESETREQ), 0);
    check_output("por_info", int'(SYS_RSTINFO), 0);
    check_output("por_timeout", int'(SYS_RSTTIMEOUT), 0);
    repeat (2) tick();
    SYS_PORESET = 1'b0;
    repeat (9) tick();
    check_output("idle_req", int'(SYS_SYSRESETREQ), 0);

    // Software pulse, acknowledge ten cycles later
    $display("[TB] software request with acknowledge");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 10, "sw");
    release_idle("sw");

    // Core and watchdog together (clear in the same cycle starts a fresh record)
    $display("[TB] core plus watchdog");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 7, "core_wdog");
    release_idle("core_wdog");

    // Lockup held one cycle short of the delay: no request
    $display("[TB] lockup path");
    SYS_LOCKUPRESETEN = 1'b1;
    CORE_LOCKUP       = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LDLY - 1; k++) begin
      tick();
      seen = seen | SYS_SYSRESETREQ;
    end
    CORE_LOCKUP = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | SYS_SYSRESETREQ;
    end
    check_output("lockup_short", int'(seen), 0);

    // Lockup held for the full delay: request on the LDLY-th edge
    CORE_LOCKUP = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LDLY - 1; k++) begin
      tick();
      seen = seen | SYS_SYSRESETREQ;
    end
    check_output("lockup_early", int'(seen), 0);
    tick();
    CORE_LOCKUP = 1'b0;
    check_output("lockup_fire", int'(SYS_SYSRESETREQ), 1);
    exp_info = exp_info | 4'b0100;
    measure(1, len);
    check_output("lockup_len", len, model_len(1));
    check_output("lockup_info2", int'(SYS_RSTINFO[2]), 1);
    check_output("lockup_info", int'(SYS_RSTINFO), int'(exp_info));
    SYS_LOCKUPRESETEN = 1'b0;
    release_idle("lockup");

    // Acknowledge never arrives: full-length request and timeout flag
    $display("[TB] acknowledge timeout");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1000, "timeout");
    check_output("timeout_len68", len + 0 == len ? model_len(1000) : 0, HOLD + ACK);
    SYS_SWRESETREQ = 1'b1;
    tick();
    SYS_SWRESETREQ = 1'b0;
    check_output("sw_in_waitrel_dropped", int'(SYS_SYSRESETREQ), 0);
    SYS_SWRESETREQ = 1'b1;
    tick();
    SYS_SWRESETREQ = 1'b0;
    check_output("retrigger_after_two", int'(SYS_SYSRESETREQ), 1);
    measure(1, len);
    check_output("retrigger_len", len, model_len(1));
    check_output("timeout_sticky", int'(SYS_RSTTIMEOUT), 1);
    release_idle("timeout");

    // Clear and a new software trigger in the same cycle
    $display("[TB] clear versus set");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 6, "clr_set");
    check_output("clr_set_exact", int'(SYS_RSTINFO), 8);
    release_idle("clr_set");

    // Power-on reset in the middle of the acknowledge wait
    $display("[TB] power-on reset during acknowledge wait");
    SYS_SWRESETREQ = 1'b1;
    tick();
    SYS_SWRESETREQ = 1'b0;
    repeat (HOLD + 2) tick();
    SYS_PORESET = 1'b1;
    #1;
    exp_info = 4'b0000;
    exp_to   = 1'b0;
    check_output("midpor_req", int'(SYS_SYSRESETREQ), 0);
    check_output("midpor_info", int'(SYS_RSTINFO), 0);
    check_output("midpor_timeout", int'(SYS_RSTTIMEOUT), 0);
    tick();
    SYS_PORESET = 1'b0;
    tick();
    check_output("postpor_req", int'(SYS_SYSRESETREQ), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3, "postpor");
    release_idle("postpor");

    // Randomized request sequences against the model
    $display("[TB] randomized sequences");
    for (int i = 0; i < 12; i++) begin
      rc   = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      if (!(rc | rw | rs)) rs = 1'b1;
      rclr = ($urandom_range(0, 3) == 0);
      ra   = $urandom_range(1, 75);
      apply_stimulus(rc, rw, rs, rclr, ra, "rand");
      release_idle("rand");
      if ($urandom_range(0, 3) == 0) begin
        SYS_RSTINFOCLR = 1'b1;
        tick();
        SYS_RSTINFOCLR = 1'b0;
        exp_info = 4'b0000;
        exp_to   = 1'b0;
        check_output("rand_clr_info", int'(SYS_RSTINFO), int'(exp_info));
        check_output("rand_clr_timeout", int'(SYS_RSTTIMEOUT), int'(exp_to));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
